adcif: RTL and testbench

- I2S receiver and slave, the receive-side counterpart of the audio DAC interface.
- Samples externally driven LRCK/BCK/DATA (asynchronous to clk) through synchronizers and deserializes MSB-first, one-BCK-delayed I2S words.
- Presents stereo 24-bit two's-complement sample pairs to the audio block with a valid strobe, or through a small ready/valid FIFO when compiled in.

---
 rtl/adcif_pkg.sv | 8 +
 rtl/adcif_sync.sv | 18 +
 rtl/adcif.sv | 125 ++++++++++++
 tb/tb_adcif.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adcif_pkg.sv
// Shared audio definitions for the I2S receive path: sample width, channel
// encoding and bit-counter width.
package adcif_pkg;
  localparam int   ADCIF_SAMPLE_BITS = 24;
  localparam logic I2S_LEFT          = 1'b0;
  localparam logic I2S_RIGHT         = 1'b1;
  localparam int   BIT_CNT_W         = 8;
endpackage

// File: rtl/adcif_sync.sv
// Multi-stage flop synchronizer for one asynchronous I2S pin.
module adcif_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/adcif.sv
// I2S slave receiver: deserializes MSB-first stereo words into sample pairs.
// Build option ADCIF_FIFO_EN adds a FIFO_DEPTH-entry ready/valid pair FIFO.
module adcif
  import adcif_pkg::*;
#(
  parameter int SAMPLE_BITS = ADCIF_SAMPLE_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i2s_lrck,
  input  logic                   i2s_bck,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   overflow_clr
);
  localparam logic [SAMPLE_BITS-1:0] MSB_ONE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  logic lrck_s, bck_s, data_s, bck_d, bck_rise;
  logic prev_lrck, sync_ok, emit;
  logic [BIT_CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic [SAMPLE_BITS-1:0] shreg, shreg_nxt, left_hold;

  adcif_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (.clk(clk), .rst_n(rst_n), .d(i2s_lrck), .q(lrck_s));
  adcif_sync #(.STAGES(SYNC_STAGES)) u_sync_bck  (.clk(clk), .rst_n(rst_n), .d(i2s_bck),  .q(bck_s));
  adcif_sync #(.STAGES(SYNC_STAGES)) u_sync_data (.clk(clk), .rst_n(rst_n), .d(i2s_data), .q(data_s));

  assign bck_rise = bck_s & ~bck_d;
  assign cnt_nxt  = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
  // Bits past SAMPLE_BITS shift the marker out entirely, which truncates long words.
  assign shreg_nxt = shreg | ((MSB_ONE >> bit_cnt) & {SAMPLE_BITS{data_s}});
  assign emit = bck_rise && (lrck_s != prev_lrck) && (prev_lrck == I2S_RIGHT) && sync_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bck_d     <= 1'b0;
      prev_lrck <= I2S_LEFT;
      sync_ok   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
    end else begin
      bck_d <= bck_s;
      if (bck_rise) begin
        prev_lrck <= lrck_s;
        if (lrck_s != prev_lrck) begin
          shreg   <= '0;
          bit_cnt <= '0;
          if (prev_lrck == I2S_LEFT) left_hold <= shreg_nxt;
          else                       sync_ok   <= 1'b1;
        end else begin
          shreg   <= shreg_nxt;
          bit_cnt <= cnt_nxt;
          // A word that never ends means the framing is lost; wait for a fresh R->L edge.
          if (cnt_nxt == '1) sync_ok <= 1'b0;
        end
      end
    end
  end

`ifdef ADCIF_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [SAMPLE_BITS-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   pop, full, push_ok;

  assign pop          = sample_valid && sample_ready;
  assign full         = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok      = emit && (!full || pop);
  assign sample_valid = (count != '0);
  assign left_data    = mem_l[rd_ptr];
  assign right_data   = mem_r[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_l[wr_ptr] <= left_hold;
        mem_r[wr_ptr] <= shreg_nxt;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      if (emit && !push_ok) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= emit;
      if (emit) begin
        left_data  <= left_hold;
        right_data <= shreg_nxt;
      end
    end
  end

  assign overflow = 1'b0;

  logic unused_in;
  assign unused_in = &{1'b0, sample_ready, overflow_clr};
  localparam int unused_depth = FIFO_DEPTH;
`endif
endmodule

// File: tb/tb_adcif.sv
// Directed I2S stream bench for adcif with an expected-pair scoreboard.
`timescale 1ns/1ps
module tb_adcif;
  localparam int SB   = 24;
  localparam int HALF = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i2s_lrck = 1'b0, i2s_bck = 1'b0, i2s_data = 1'b0;
  logic sample_ready = 1'b1, overflow_clr = 1'b0;
  logic [SB-1:0] left_data, right_data;
  logic sample_valid, overflow;

  adcif #(.SAMPLE_BITS(SB), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_lrck(i2s_lrck), .i2s_bck(i2s_bck), .i2s_data(i2s_data),
    .left_data(left_data), .right_data(right_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, n_valid = 0, snap = 0;
  logic [2*SB-1:0] exp_q[$];
  logic pend = 1'b0;
  logic valid_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    logic [2*SB-1:0] e;
    n_valid++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_valid: got L=%h R=%h expected no pair", left_data, right_data);
    end else begin
      e = exp_q.pop_front();
      check("left_data", 64'(left_data), 64'(e[2*SB-1:SB]));
      check("right_data", 64'(right_data), 64'(e[SB-1:0]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
`ifdef ADCIF_FIFO_EN
      if (sample_valid && sample_ready) pop_check();
`else
      if (sample_valid) begin
        pop_check();
        check("valid_width", 64'(valid_d), 64'd0);
      end
`endif
    end
    valid_d = sample_valid;
  end

  task automatic push_exp(input logic [SB-1:0] l, input logic [SB-1:0] r);
    exp_q.push_back({l, r});
  endtask

  task automatic bck_slot(input logic w, input logic d);
    repeat (HALF) @(posedge clk);
    #1;
    i2s_bck = 1'b0; i2s_lrck = w; i2s_data = d;
    repeat (HALF) @(posedge clk);
    #1;
    i2s_bck = 1'b1;
  endtask

  // Slot 0 of a channel carries the previous word's LSB (one-BCK I2S delay).
  task automatic send_part(input logic w, input logic [31:0] val, input int m, input int from, input int upto);
    logic [31:0] sh;
    for (int i = from; i < upto; i++) begin
      sh = val << (i - 1);
      bck_slot(w, (i == 0) ? pend : sh[31]);
    end
    if (upto == m) begin
      sh = val << (m - 1);
      pend = sh[31];
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int m);
    send_part(1'b0, l, m, 0, m);
    send_part(1'b1, r, m, 0, m);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", 64'(left_data), 64'd0);
    check("rst_right", 64'(right_data), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // 32-BCK slots, 24-bit payload; first frame after reset is never emitted
    send_frame(32'h12345600, 32'hFEDCBA00, 32);
    send_frame(32'h12345600, 32'hFEDCBA00, 32);
    check("no_pair_before_sync", 64'(n_valid), 64'd0);
    push_exp(24'h123456, 24'hFEDCBA);
    send_frame(32'h12345600, 32'hFEDCBA00, 32);
    push_exp(24'h123456, 24'hFEDCBA);
    send_frame(32'h12345600, 32'hFEDCBA00, 32);

    // 16-bit words are zero-padded at the LSB end
    push_exp(24'h123456, 24'hFEDCBA);
    send_frame(32'h80010000, 32'h7FFF0000, 16);
    push_exp(24'h800100, 24'h7FFF00);
    send_frame(32'h80010000, 32'h7FFF0000, 16);

    // 32-bit words are truncated at the LSB end
    push_exp(24'h800100, 24'h7FFF00);
    send_frame(32'hA5A5A5FF, 32'h80000001, 32);
    push_exp(24'hA5A5A5, 24'h800000);
    send_frame(32'hA5A5A5FF, 32'h80000001, 32);

    // Stall mid-left-word: BCK static, then BCK running with no word boundary
    push_exp(24'hA5A5A5, 24'h800000);
    send_part(1'b0, 32'h0F0F0F00, 32, 0, 12);
    snap = n_valid;
    repeat (300 * 2 * HALF) @(posedge clk);
    check("bck_static_no_valid", 64'(n_valid), 64'(snap));
    for (int i = 0; i < 300; i++) bck_slot(1'b0, 1'b0);
    pend = 1'b0;
    send_frame(32'h0F0F0F00, 32'hF0F0F000, 32);
    send_frame(32'h0F0F0F00, 32'hF0F0F000, 32);
    check("stall_resync_no_valid", 64'(n_valid), 64'(snap));
    push_exp(24'h0F0F0F, 24'hF0F0F0);
    send_frame(32'h0F0F0F00, 32'hF0F0F000, 32);
    wait_drain();

`ifdef ADCIF_FIFO_EN
    push_exp(24'h0F0F0F, 24'hF0F0F0);
    send_frame({8'h01, 24'h0}, {8'h81, 24'h0}, 32);
    wait_drain();
    sample_ready = 1'b0;
    push_exp(24'h010000, 24'h810000);
    push_exp(24'h020000, 24'h820000);
    push_exp(24'h030000, 24'h830000);
    push_exp(24'h040000, 24'h840000);
    for (int n = 2; n <= 7; n++) send_frame({8'(n), 24'h0}, {8'(8'h80 + n), 24'h0}, 32);
    #1;
    check("fifo_held_valid", 64'(sample_valid), 64'd1);
    check("fifo_head_left", 64'(left_data), 64'h010000);
    check("fifo_overflow_set", 64'(overflow), 64'd1);
    @(posedge clk);
    #1;
    sample_ready = 1'b1;
    wait_drain();
    check("fifo_overflow_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    check("fifo_overflow_cleared", 64'(overflow), 64'd0);
    push_exp(24'h070000, 24'h870000);
`else
    check("no_fifo_overflow_low", 64'(overflow), 64'd0);
    push_exp(24'h0F0F0F, 24'hF0F0F0);
`endif

    // Reset in the middle of a right word
    send_part(1'b0, 32'h11223300, 32, 0, 32);
    send_part(1'b1, 32'h44556600, 32, 0, 10);
    wait_drain();
    rst_n = 1'b0;
    #1;
    check("midrst_left", 64'(left_data), 64'd0);
    check("midrst_right", 64'(right_data), 64'd0);
    check("midrst_valid", 64'(sample_valid), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_part(1'b1, 32'h44556600, 32, 10, 32);
    snap = n_valid;
    send_frame(32'h778899AA, 32'hBBCCDDEE, 32);
    check("midrst_no_partial_pair", 64'(n_valid), 64'(snap));
    push_exp(24'h778899, 24'hBBCCDD);
    send_frame(32'hC0FFEE00, 32'h0BADF000, 32);
    push_exp(24'hC0FFEE, 24'h0BADF0);
    send_part(1'b0, 32'h0, 32, 0, 4);
    wait_drain();
    check("valid_pulse_count", 64'(n_valid), 64'(snap + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
